// File: rtl/fuel_alarm_sequencer.sv
// fuel_alarm_sequencer: fuel level alarm FSM with hysteresis, lamp, buzzer, range.
// Optional logging outputs are enabled by defining FUEL_ALARM_LOG_EN.
module fuel_alarm_sequencer #(
    parameter int unsigned WARN_LEVEL  = 5,
    parameter int unsigned CRIT_LEVEL  = 2,
    parameter int unsigned HYST        = 1,
    parameter int unsigned BLINK_HALF  = 4,
    parameter int unsigned BUZZ_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [4:0]  remaining_fuel,
    input  logic [7:0]  mileage,
    input  logic        ack,
    output logic [1:0]  alarm_state,
    output logic        warn_lamp,
    output logic        buzzer,
    output logic [12:0] range_km,
    output logic        range_valid,
`ifdef FUEL_ALARM_LOG_EN
    output logic [7:0]  crit_count,
    output logic [4:0]  min_fuel_seen,
`endif
    output logic        refuel_event
);

    typedef enum logic [1:0] {
        S_NORMAL = 2'b00,
        S_WARN   = 2'b01,
        S_CRIT   = 2'b10,
        S_EMPTY  = 2'b11
    } state_t;

    localparam logic [4:0] L_WARN   = 5'(WARN_LEVEL);
    localparam logic [4:0] L_CRIT   = 5'(CRIT_LEVEL);
    localparam logic [4:0] L_WARN_H = 5'(WARN_LEVEL + HYST);
    localparam logic [4:0] L_CRIT_H = 5'(CRIT_LEVEL + HYST);

    localparam int BLW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int BZW = $clog2(BUZZ_CYCLES + 1);
    localparam logic [BLW-1:0] L_BLINK_MAX = BLW'(BLINK_HALF - 1);
    localparam logic [BZW-1:0] L_BUZZ      = BZW'(BUZZ_CYCLES);

    state_t          r_state;
    state_t          w_target;
    state_t          w_next;
    logic            w_esc;
    logic            w_crit_entry;
    logic [12:0]     w_range;

    logic [12:0]     r_range;
    logic            r_rvalid;
    logic            r_refuel;
    logic [4:0]      r_last_fuel;
    logic            r_first;
    logic [BLW-1:0]  r_blink_cnt;
    logic            r_blink;
    logic [BZW-1:0]  r_buzz_cnt;

    assign w_range = 13'(remaining_fuel) * 13'(mileage);

    // Level classification, hysteresis-gated next state and lamp output
    always_comb begin
        w_target     = S_NORMAL;
        w_next       = r_state;
        w_esc        = 1'b0;
        w_crit_entry = 1'b0;
        warn_lamp    = 1'b0;

        if (remaining_fuel == 5'd0) begin
            w_target = S_EMPTY;
        end else if (remaining_fuel <= L_CRIT) begin
            w_target = S_CRIT;
        end else if (remaining_fuel <= L_WARN) begin
            w_target = S_WARN;
        end

        if (sample_valid) begin
            if (w_target > r_state) begin
                w_next = w_target;
            end else if (w_target < r_state) begin
                case (r_state)
                    S_EMPTY: w_next = w_target;
                    S_CRIT:  if (remaining_fuel > L_CRIT_H) w_next = w_target;
                    S_WARN:  if (remaining_fuel > L_WARN_H) w_next = w_target;
                    default: w_next = r_state;
                endcase
            end
        end

        w_esc        = (w_next > r_state) && (w_next >= S_CRIT);
        w_crit_entry = (w_next == S_CRIT) && (r_state != S_CRIT);

        case (r_state)
            S_WARN:  warn_lamp = 1'b1;
            S_CRIT:  warn_lamp = r_blink;
            S_EMPTY: warn_lamp = 1'b1;
            default: warn_lamp = 1'b0;
        endcase
    end

    // Alarm state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_NORMAL;
        end else begin
            r_state <= w_next;
        end
    end

    // Range latch, range strobe and refuel detection on each sample
    always_ff @(posedge clk) begin
        if (reset) begin
            r_range     <= '0;
            r_rvalid    <= 1'b0;
            r_refuel    <= 1'b0;
            r_last_fuel <= '0;
            r_first     <= 1'b1;
        end else begin
            r_rvalid <= sample_valid;
            r_refuel <= 1'b0;
            if (sample_valid) begin
                r_range     <= w_range;
                r_last_fuel <= remaining_fuel;
                r_first     <= 1'b0;
                r_refuel    <= !r_first && (remaining_fuel > r_last_fuel);
            end
        end
    end

    // CRIT blink generator, restarted lit on every CRIT entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_crit_entry) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (w_next == S_CRIT) begin
            if (r_blink_cnt == L_BLINK_MAX) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end
    end

    // Buzzer timer: escalation reloads and beats ack, ack silences
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buzz_cnt <= '0;
        end else if (w_esc) begin
            r_buzz_cnt <= L_BUZZ;
        end else if (ack) begin
            r_buzz_cnt <= '0;
        end else if (r_buzz_cnt != '0) begin
            r_buzz_cnt <= r_buzz_cnt - 1'b1;
        end
    end

`ifdef FUEL_ALARM_LOG_EN
    logic [7:0] r_crit_count;
    logic [4:0] r_min_fuel;

    // Severe-entry counter and minimum-fuel tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crit_count <= '0;
            r_min_fuel   <= 5'd31;
        end else begin
            if (w_esc && (r_state <= S_WARN) && (r_crit_count != 8'hFF)) begin
                r_crit_count <= r_crit_count + 1'b1;
            end
            if (sample_valid && (remaining_fuel < r_min_fuel)) begin
                r_min_fuel <= remaining_fuel;
            end
        end
    end

    assign crit_count    = r_crit_count;
    assign min_fuel_seen = r_min_fuel;
`endif

    assign alarm_state  = r_state;
    assign buzzer       = (r_buzz_cnt != '0);
    assign range_km     = r_range;
    assign range_valid  = r_rvalid;
    assign refuel_event = r_refuel;

endmodule

// File: tb/tb_fuel_alarm_sequencer.sv
// tb_fuel_alarm_sequencer: table vectors plus scoreboard queue for samples,
// hand sequences for blink, buzzer, ack priority and mid-buzz reset.
module tb_fuel_alarm_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [4:0]  remaining_fuel = '0;
    logic [7:0]  mileage = '0;
    logic        ack = 1'b0;
    logic [1:0]  alarm_state;
    logic        warn_lamp;
    logic        buzzer;
    logic [12:0] range_km;
    logic        range_valid;
    logic        refuel_event;
`ifdef FUEL_ALARM_LOG_EN
    logic [7:0]  crit_count;
    logic [4:0]  min_fuel_seen;
`endif

    always #5 clk = ~clk;

    fuel_alarm_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .remaining_fuel (remaining_fuel),
        .mileage        (mileage),
        .ack            (ack),
        .alarm_state    (alarm_state),
        .warn_lamp      (warn_lamp),
        .buzzer         (buzzer),
        .range_km       (range_km),
        .range_valid    (range_valid),
`ifdef FUEL_ALARM_LOG_EN
        .crit_count     (crit_count),
        .min_fuel_seen  (min_fuel_seen),
`endif
        .refuel_event   (refuel_event)
    );

    typedef struct {
        logic [4:0]  fuel;
        logic [7:0]  mil;
        logic [1:0]  st;
        logic [12:0] rng;
        logic        rf;
        logic        lamp;
        logic        buzz;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [12:0] rng;
        logic        rf;
    } exp_t;

    vec_t tbl [12];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Drive one strobe, push its expectation, pop and compare after the edge
    task automatic do_sample(input logic [4:0] f, input logic [7:0] m,
                             input logic a, input logic [1:0] st,
                             input logic [12:0] rng, input logic rf);
        exp_t e;
        e.st = st;
        e.rng = rng;
        e.rf = rf;
        sb.push_back(e);
        remaining_fuel = f;
        mileage = m;
        ack = a;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        ack = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("range_valid", int'(range_valid), 1);
            chk("range_km", int'(range_km), int'(e.rng));
            chk("alarm_state", int'(alarm_state), int'(e.st));
            chk("refuel_event", int'(refuel_event), int'(e.rf));
        end
    endtask

    initial begin
        tbl[0]  = '{5'd15, 8'd10,  2'd0, 13'd150,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{5'd5,  8'd10,  2'd1, 13'd50,   1'b0, 1'b1, 1'b0};
        tbl[2]  = '{5'd2,  8'd12,  2'd2, 13'd24,   1'b0, 1'b1, 1'b1};
        tbl[3]  = '{5'd3,  8'd10,  2'd2, 13'd30,   1'b1, 1'b1, 1'b1};
        tbl[4]  = '{5'd4,  8'd10,  2'd1, 13'd40,   1'b1, 1'b1, 1'b1};
        tbl[5]  = '{5'd6,  8'd10,  2'd1, 13'd60,   1'b1, 1'b1, 1'b1};
        tbl[6]  = '{5'd7,  8'd10,  2'd0, 13'd70,   1'b1, 1'b0, 1'b1};
        tbl[7]  = '{5'd7,  8'd10,  2'd0, 13'd70,   1'b0, 1'b0, 1'b1};
        tbl[8]  = '{5'd0,  8'd9,   2'd3, 13'd0,    1'b0, 1'b1, 1'b1};
        tbl[9]  = '{5'd1,  8'd20,  2'd2, 13'd20,   1'b1, 1'b1, 1'b1};
        tbl[10] = '{5'd10, 8'd3,   2'd0, 13'd30,   1'b1, 1'b0, 1'b1};
        tbl[11] = '{5'd31, 8'd255, 2'd0, 13'd7905, 1'b1, 1'b0, 1'b1};

        // Reset state
        tick();
        do_reset();
        chk("rst_state", int'(alarm_state), 0);
        chk("rst_lamp", int'(warn_lamp), 0);
        chk("rst_buzzer", int'(buzzer), 0);
        chk("rst_range", int'(range_km), 0);
        chk("rst_rvalid", int'(range_valid), 0);
        chk("rst_refuel", int'(refuel_event), 0);

        // Table vectors, each followed by one idle (hold) cycle
        for (int i = 0; i < 12; i++) begin
            do_sample(tbl[i].fuel, tbl[i].mil, 1'b0, tbl[i].st,
                      tbl[i].rng, tbl[i].rf);
            chk($sformatf("v%0d_lamp", i), int'(warn_lamp), int'(tbl[i].lamp));
            chk($sformatf("v%0d_buzz", i), int'(buzzer), int'(tbl[i].buzz));
            tick();
            chk($sformatf("v%0d_hold_rv", i), int'(range_valid), 0);
            chk($sformatf("v%0d_hold_rf", i), int'(refuel_event), 0);
            chk($sformatf("v%0d_hold_rng", i), int'(range_km), int'(tbl[i].rng));
            chk($sformatf("v%0d_hold_st", i), int'(alarm_state), int'(tbl[i].st));
        end

        // Blink and buzzer timing after a direct NORMAL->CRIT entry
        do_reset();
        do_sample(5'd15, 8'd10, 1'b0, 2'd0, 13'd150, 1'b0);
        tick();
        do_sample(5'd2, 8'd10, 1'b0, 2'd2, 13'd20, 1'b0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("blink_k%0d", k), int'(warn_lamp),
                ((k / 4) % 2 == 0) ? 1 : 0);
            chk($sformatf("buzz_k%0d", k), int'(buzzer), (k < 16) ? 1 : 0);
            tick();
        end

        // Ack at cycle 5 silences the buzzer on the next cycle
        do_reset();
        do_sample(5'd15, 8'd10, 1'b0, 2'd0, 13'd150, 1'b0);
        do_sample(5'd2, 8'd10, 1'b0, 2'd2, 13'd20, 1'b0);
        for (int k = 1; k <= 5; k++) tick();
        chk("ack_pre_buzz", int'(buzzer), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_buzz_off", int'(buzzer), 0);
        tick();
        chk("ack_buzz_stays_off", int'(buzzer), 0);
        chk("ack_state_crit", int'(alarm_state), 2);

        // Ack coinciding with escalation to EMPTY: full reload wins
        do_reset();
        do_sample(5'd15, 8'd10, 1'b0, 2'd0, 13'd150, 1'b0);
        do_sample(5'd2, 8'd10, 1'b0, 2'd2, 13'd20, 1'b0);
        tick();
        tick();
        tick();
        chk("esc_pre_buzz", int'(buzzer), 1);
        do_sample(5'd0, 8'd10, 1'b1, 2'd3, 13'd0, 1'b0);
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("esc_buzz_k%0d", k), int'(buzzer), (k < 16) ? 1 : 0);
            tick();
        end
        chk("esc_lamp_empty", int'(warn_lamp), 1);

        // Reset asserted mid-buzz aborts everything
        do_reset();
        do_sample(5'd15, 8'd10, 1'b0, 2'd0, 13'd150, 1'b0);
        do_sample(5'd1, 8'd10, 1'b0, 2'd2, 13'd10, 1'b0);
        tick();
        tick();
        chk("mid_pre_buzz", int'(buzzer), 1);
        do_reset();
        chk("mid_state", int'(alarm_state), 0);
        chk("mid_lamp", int'(warn_lamp), 0);
        chk("mid_buzzer", int'(buzzer), 0);
        chk("mid_range", int'(range_km), 0);
        chk("mid_rvalid", int'(range_valid), 0);
        chk("mid_refuel", int'(refuel_event), 0);
        tick();
        chk("mid_buzz_after", int'(buzzer), 0);
        do_sample(5'd31, 8'd255, 1'b0, 2'd0, 13'd7905, 1'b0);

`ifdef FUEL_ALARM_LOG_EN
        // Three NORMAL->CRIT entries with minimum fuel 1
        do_reset();
        chk("log_rst_cnt", int'(crit_count), 0);
        chk("log_rst_min", int'(min_fuel_seen), 31);
        for (int r = 0; r < 3; r++) begin
            do_sample(5'd10, 8'd10, 1'b0, 2'd0, 13'd100, (r > 0) ? 1'b1 : 1'b0);
            do_sample(5'd1, 8'd10, 1'b0, 2'd2, 13'd10, 1'b0);
        end
        chk("log_crit_count", int'(crit_count), 3);
        chk("log_min_fuel", int'(min_fuel_seen), 1);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
